fetch_unit: RTL and testbench

Instruction fetch stage for the single-issue RISC-V core. Holds the program counter, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents them to decode over a valid/ready handshake. Consumes the ALU's resolved branch flags (eq_flag, less_flag) and jump targets to redirect the PC, flushing any in-flight fetch.

---
 rtl/fetch_unit_pkg.sv | 28 ++
 rtl/fetch_unit_branch_resolve.sv | 23 ++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the ALU-facing branch flags.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

  // Flag pair produced by the ALU comparator for conditional branches.
  typedef struct packed {
    logic eq_flag;
    logic less_flag;
  } alu_flags_t;

  // Branch funct3 encodings.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/fetch_unit_branch_resolve.sv
// Decides whether a resolved conditional branch is taken from its funct3 and ALU flags.
module branch_resolve
  import fetch_unit_pkg::*;
(
  input  logic [2:0] branch_type,
  input  logic       eq_flag,
  input  logic       less_flag,
  output logic       taken
);

  // Signed and unsigned compares share one less_flag; unknown funct3 is never taken.
  always_comb begin
    taken = 1'b0;
    case (branch_type)
      F3_BEQ:            taken = eq_flag;
      F3_BNE:            taken = ~eq_flag;
      F3_BLT, F3_BLTU:   taken = less_flag;
      F3_BGE, F3_BGEU:   taken = ~less_flag | eq_flag;
      default:           taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack fetch, decode valid/ready, branch/jump redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  input  logic        branch_valid,
  input  logic [2:0]  branch_type,
  input  logic        eq_flag,
  input  logic        less_flag,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic        fetch_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         branch_taken;
  logic         redirect;
  logic [31:0]  redirect_target;

  branch_resolve u_branch_resolve (
    .branch_type (branch_type),
    .eq_flag     (eq_flag),
    .less_flag   (less_flag),
    .taken       (branch_taken)
  );

  // Jumps win over branches when both arrive in the same cycle.
  always_comb begin
    redirect        = jump_valid | (branch_valid & branch_taken);
    redirect_target = jump_valid ? jump_target : branch_target;
  end

  // Next-state logic; a redirect overrides any same-cycle ack or ready handshake.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    if (state_q != ERR && redirect) begin
      if (redirect_target[1:0] != 2'b00) begin
        state_d = ERR;
      end else begin
        pc_d    = redirect_target;
        state_d = halt ? IDLE : REQ;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!halt) state_d = REQ;
        end
        REQ: begin
          if (imem_ack) begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            state_d  = VALID;
          end
        end
        VALID: begin
          if (instr_ready) begin
            pc_d    = pc_q + INSTR_BYTES;
            state_d = halt ? IDLE : REQ;
          end
        end
        default: state_d = ERR;
      endcase
    end
  end

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      pc_out_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign fetch_err   = (state_q == ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory/decode model on the falling edge.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        nRst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic        branch_valid;
  logic [2:0]  branch_type;
  logic        eq_flag;
  logic        less_flag;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        halt;
  logic        fetch_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetchItem_t;

  int          total = 0;
  int          bad = 0;
  bit          memOn;
  bit          readyOn;
  bit          haltIn;
  logic [31:0] expAddr;
  logic [31:0] savedInstr;
  logic [31:0] savedPc;
  fetchItem_t  sbQueue[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .nRst          (nRst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc_out        (pc_out),
    .branch_valid  (branch_valid),
    .branch_type   (branch_type),
    .eq_flag       (eq_flag),
    .less_flag     (less_flag),
    .branch_target (branch_target),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .halt          (halt),
    .fetch_err     (fetch_err)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic modelTaken(input logic [2:0] bt, input logic eqF, input logic ltF);
    case (bt)
      3'b000:         return eqF;
      3'b001:         return !eqF;
      3'b100, 3'b110: return ltF;
      3'b101, 3'b111: return !ltF || eqF;
      default:        return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: check outputs, model memory/decode, drive inputs, advance one cycle.
  task automatic applyStimulus(input logic bv, input logic [2:0] bt, input logic eqF, input logic ltF,
                               input logic [31:0] btgt, input logic jv, input logic [31:0] jtgt);
    logic       redir;
    fetchItem_t item;
    redir = jv || (bv && modelTaken(bt, eqF, ltF));
    if (instr_valid) begin
      if (redir) begin
        if (sbQueue.size() > 0) void'(sbQueue.pop_front());
      end else if (readyOn) begin
        if (sbQueue.size() == 0) begin
          checkOutput("sbEmpty", 32'd1, 32'd0);
        end else begin
          item = sbQueue.pop_front();
          checkOutput("instr", instr, item.word);
          checkOutput("pcOut", pc_out, item.pc);
        end
        expAddr = expAddr + 32'd4;
      end
    end
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    if (imem_req) begin
      checkOutput("imemAddr", imem_addr, expAddr);
      if (memOn) begin
        imem_ack   = 1'b1;
        imem_rdata = memWord(imem_addr);
        if (!redir) sbQueue.push_back({expAddr, memWord(expAddr)});
      end
    end
    if (redir) expAddr = jv ? jtgt : btgt;
    branch_valid  = bv;
    branch_type   = bt;
    eq_flag       = eqF;
    less_flag     = ltF;
    branch_target = btgt;
    jump_valid    = jv;
    jump_target   = jtgt;
    instr_ready   = readyOn;
    halt          = haltIn;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Runs with decode stalled until an instruction is presented, bounded.
  task automatic waitValid();
    for (int i = 0; i < 20 && !instr_valid; i++) idleCycles(1);
    if (!instr_valid) checkOutput("waitValid", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    nRst = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_type = 3'b000; eq_flag = 1'b0; less_flag = 1'b0;
    branch_target = 32'h0; jump_valid = 1'b0; jump_target = 32'h0; halt = 1'b0;
    memOn = 1'b0; readyOn = 1'b0; haltIn = 1'b0; expAddr = 32'h0;
    @(negedge clk);
    @(negedge clk);

    checkOutput("rstReq", imem_req, 32'd0);
    checkOutput("rstValid", instr_valid, 32'd0);
    checkOutput("rstInstr", instr, 32'h0);
    checkOutput("rstPcOut", pc_out, 32'h0);
    checkOutput("rstErr", fetch_err, 32'd0);

    // Zero-wait memory, decode always ready: 0x0, 0x4, 0x8, 0xC.
    nRst = 1'b1; memOn = 1'b1; readyOn = 1'b1;
    idleCycles(8);

    // Decode stall holds the instruction and blocks the next fetch.
    readyOn = 1'b0;
    waitValid();
    savedInstr = instr;
    savedPc    = pc_out;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stallInstr", instr, savedInstr);
      checkOutput("stallPc", pc_out, savedPc);
      checkOutput("stallReq", imem_req, 32'd0);
      checkOutput("stallValid", instr_valid, 32'd1);
      idleCycles(1);
    end
    readyOn = 1'b1;
    idleCycles(1);
    checkOutput("reqAfterReady", imem_req, 32'd1);
    checkOutput("addrAfterReady", imem_addr, savedPc + 32'd4);

    // Conditional branches resolved while an instruction waits in decode.
    readyOn = 1'b0;
    waitValid();
    applyStimulus(1'b1, F3_BNE, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0);
    checkOutput("bneValid", instr_valid, 32'd0);
    checkOutput("bneReq", imem_req, 32'd1);
    checkOutput("bneAddr", imem_addr, 32'h100);
    waitValid();
    applyStimulus(1'b1, F3_BNE, 1'b1, 1'b0, 32'h180, 1'b0, 32'h0);
    checkOutput("bneNotTaken", instr_valid, 32'd1);
    applyStimulus(1'b1, F3_BGE, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    checkOutput("bgeEqValid", instr_valid, 32'd0);
    checkOutput("bgeEqAddr", imem_addr, 32'h300);
    waitValid();
    applyStimulus(1'b1, F3_BGE, 1'b0, 1'b1, 32'h380, 1'b0, 32'h0);
    checkOutput("bgeLtNotTaken", instr_valid, 32'd1);
    applyStimulus(1'b1, F3_BLTU, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    checkOutput("bltuReq", imem_req, 32'd1);
    checkOutput("bltuAddr", imem_addr, 32'h400);

    // Jump to 0x40, then a jump to 0x200 coinciding with the 0x40 ack.
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    checkOutput("jmp40Addr", imem_addr, 32'h40);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    checkOutput("jmpAckValid", instr_valid, 32'd0);
    checkOutput("jmpAckReq", imem_req, 32'd1);
    checkOutput("jmpAckAddr", imem_addr, 32'h200);
    waitValid();
    checkOutput("pcAfterJump", pc_out, 32'h200);
    checkOutput("instrAfterJump", instr, memWord(32'h200));

    // Halt while accepting: no new request until halt drops.
    readyOn = 1'b1; haltIn = 1'b1;
    idleCycles(1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("haltReq", imem_req, 32'd0);
      idleCycles(1);
    end
    haltIn = 1'b0;
    idleCycles(1);
    checkOutput("resumeReq", imem_req, 32'd1);
    checkOutput("resumeAddr", imem_addr, 32'h204);

    // Misaligned jump target locks the stage in error until reset.
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h202);
    for (int i = 0; i < 3; i++) begin
      checkOutput("errFlag", fetch_err, 32'd1);
      checkOutput("errReq", imem_req, 32'd0);
      checkOutput("errValid", instr_valid, 32'd0);
      idleCycles(1);
    end
    nRst = 1'b0;
    #1;
    checkOutput("asyncRstErr", fetch_err, 32'd0);
    checkOutput("asyncRstPcOut", pc_out, 32'h0);
    checkOutput("asyncRstReq", imem_req, 32'd0);
    sbQueue.delete();
    expAddr = 32'h0;
    @(negedge clk);
    nRst = 1'b1;
    idleCycles(1);
    checkOutput("restartAddr", imem_addr, 32'h0);
    idleCycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
